// File: rtl/cla_pkg.sv
// Shared definitions for the pipelined carry-lookahead adder: group bookkeeping,
// the parameter legality check and the control half of the stage record.
`ifndef CLA_PKG_SV
`define CLA_PKG_SV

// Stops elaboration on an unusable WIDTH/BLOCK/STAGES combination.
`define CLA_PARAM_CHECK(W, B, S) \
  if ((B) < 1 || ((W) % (B)) != 0 || (S) < 1 || (S) > ((W) / (B)) || (((W) / (B)) % (S)) != 0) begin : g_param_check \
    $error("cla_adder_pipe: illegal parameters WIDTH=%0d BLOCK=%0d STAGES=%0d", W, B, S); \
  end

package cla_pkg;

  function automatic int group_count(input int width, input int block);
    return width / block;
  endfunction

  function automatic int groups_per_stage(input int width, input int block, input int stages);
    return width / (block * stages);
  endfunction

  // Control fields carried alongside the partial sum and remaining operands.
  typedef struct packed {
    logic valid;
    logic sub;
    logic carry;
    logic ovf;
  } cla_ctrl_t;

endpackage

`endif

// File: rtl/cla_adder_pipe_if.sv
// Operand/result stream of the pipelined adder: valid/ready in, valid/ready out.
interface cla_adder_pipe_if #(
  parameter int WIDTH = 32
);
  logic             valid_i;
  logic             ready_o;
  logic [WIDTH-1:0] A_i;
  logic [WIDTH-1:0] B_i;
  logic             Ci_i;
  logic             sub_i;
  logic             valid_o;
  logic             ready_i;
  logic [WIDTH-1:0] S_o;
  logic             Co_o;
  logic             V_o;

  modport slave (
    input  valid_i, A_i, B_i, Ci_i, sub_i, ready_i,
    output ready_o, valid_o, S_o, Co_o, V_o
  );

  modport master (
    output valid_i, A_i, B_i, Ci_i, sub_i, ready_i,
    input  ready_o, valid_o, S_o, Co_o, V_o
  );
endinterface

// File: rtl/cla_group.sv
// BLOCK-bit combinational lookahead group: flat carry terms per bit plus the
// group generate/propagate used to chain groups.
module cla_group #(
  parameter int BLOCK = 4
) (
  input  logic [BLOCK-1:0] a,
  input  logic [BLOCK-1:0] b,
  input  logic             cin,
  output logic [BLOCK-1:0] s,
  output logic             cout,
  output logic             gg,
  output logic             pg
);
  logic [BLOCK-1:0] p;
  logic [BLOCK-1:0] g;
  logic [BLOCK-1:0] c;
  logic             acc;
  logic             prod;

  assign p = a ^ b;
  assign g = a & b;

  always_comb begin
    // NOTE: every variable gets a value before any branch/loop so no latch is inferred.
    c    = '0;
    acc  = 1'b0;
    prod = 1'b0;
    gg   = 1'b0;
    pg   = 1'b0;
    c[0] = cin;
    // Carry into bit i = g[i-1] | p[i-1]g[i-2] | ... | p[i-1:0]cin, no ripple.
    for (int i = 1; i < BLOCK; i++) begin
      acc  = g[i-1];
      prod = p[i-1];
      for (int j = i - 2; j >= 0; j--) begin
        acc  = acc | (prod & g[j]);
        prod = prod & p[j];
      end
      c[i] = acc | (prod & cin);
    end
    acc  = g[BLOCK-1];
    prod = p[BLOCK-1];
    for (int j = BLOCK - 2; j >= 0; j--) begin
      acc  = acc | (prod & g[j]);
      prod = prod & p[j];
    end
    gg = acc;
    pg = prod;
  end

  assign s    = p ^ c;
  assign cout = gg | (pg & cin);
endmodule

// File: rtl/cla_adder_pipe.sv
// Pipelined CLA adder/subtractor: groups are split evenly over STAGES register
// stages, group carries chain inside a stage and are registered between stages.
module cla_adder_pipe
  import cla_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int BLOCK  = 4,
  parameter int STAGES = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  cla_adder_pipe_if.slave  bus
);
  localparam int NGROUPS = group_count(WIDTH, BLOCK);
  localparam int N       = groups_per_stage(WIDTH, BLOCK, STAGES);
  localparam logic [WIDTH-1:0] ONES = '1;

  `CLA_PARAM_CHECK(WIDTH, BLOCK, STAGES)

  typedef struct packed {
    cla_ctrl_t        ctrl;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } stage_t;

  stage_t           head;
  stage_t           pipe_q    [STAGES];
  stage_t           stage_nxt [STAGES];
  logic [WIDTH-1:0] grp_sum;
  logic             grp_gg [NGROUPS];
  logic             grp_pg [NGROUPS];
  logic             grp_co [NGROUPS];
  logic             en;

  // The whole pipe advances together; a held output freezes every stage.
  assign en          = ~pipe_q[STAGES-1].ctrl.valid | bus.ready_i;
  assign bus.ready_o = en;

  always_comb begin
    head            = '0;
    head.ctrl.valid = bus.valid_i;
    head.ctrl.sub   = bus.sub_i;
    head.ctrl.carry = bus.sub_i ? ~bus.Ci_i : bus.Ci_i;
    head.a          = bus.A_i;
    head.b          = bus.sub_i ? ~bus.B_i : bus.B_i;
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam logic [WIDTH-1:0] MASK = (ONES >> (WIDTH - N * BLOCK)) << (k * N * BLOCK);

    stage_t   cur;
    stage_t   nxt;
    logic [N:0] c;

    if (k == 0) begin : g_head
      assign cur = head;
    end else begin : g_link
      assign cur = pipe_q[k-1];
    end

    assign c[0] = cur.ctrl.carry;

    for (genvar j = 0; j < N; j++) begin : g_grp
      localparam int G = k * N + j;

      cla_group #(.BLOCK(BLOCK)) u_grp (
        .a    (cur.a[G*BLOCK +: BLOCK]),
        .b    (cur.b[G*BLOCK +: BLOCK]),
        .cin  (c[j]),
        .s    (grp_sum[G*BLOCK +: BLOCK]),
        .cout (grp_co[G]),
        .gg   (grp_gg[G]),
        .pg   (grp_pg[G])
      );

      assign c[j+1] = grp_gg[G] | (grp_pg[G] & c[j]);
    end

    always_comb begin
      nxt            = cur;
      nxt.ctrl.carry = c[N];
      nxt.sum        = (cur.sum & ~MASK) | (grp_sum & MASK);
      // Carry into the MSB is recovered from its sum bit and propagate term.
      if (k == STAGES - 1) begin
        nxt.ctrl.ovf = (grp_sum[WIDTH-1] ^ cur.a[WIDTH-1] ^ cur.b[WIDTH-1])
                     ^ grp_co[NGROUPS-1];
      end
    end

    assign stage_nxt[k] = nxt;
  end

  always_ff @(posedge clk_i) begin
    for (int k = 0; k < STAGES; k++) begin
      // NOTE: the stage registers are data, not storage, yet are cleared so the
      // outputs read zero after reset; non-blocking lets each stage see its
      // predecessor's pre-edge value.
      if (rst_i) begin
        pipe_q[k] <= '0;
      end else if (en) begin
        pipe_q[k] <= stage_nxt[k];
      end
    end
  end

  assign bus.valid_o = pipe_q[STAGES-1].ctrl.valid;
  assign bus.S_o     = pipe_q[STAGES-1].sum;
  assign bus.Co_o    = pipe_q[STAGES-1].ctrl.sub ? ~pipe_q[STAGES-1].ctrl.carry
                                                 :  pipe_q[STAGES-1].ctrl.carry;
  assign bus.V_o     = pipe_q[STAGES-1].ctrl.ovf;
endmodule

// File: tb/tb_cla_adder_pipe.sv
// Self-checking bench for cla_adder_pipe: directed corner cases, streamed random
// traffic with backpressure against an arithmetic model, flush and latency sweep.
module tb_cla_adder_pipe;
  localparam int W   = 32;
  localparam int NSW = 4;
  localparam int SW_STAGES [NSW] = '{1, 2, 4, 8};

  typedef struct packed {
    logic [W-1:0] s;
    logic         co;
    logic         v;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  cla_adder_pipe_if #(.WIDTH(W)) bus ();

  cla_adder_pipe #(.WIDTH(W), .BLOCK(4), .STAGES(2)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  logic         sw_valid_in = 1'b0;
  logic [W-1:0] sw_a = '0;
  logic [W-1:0] sw_b = '0;
  logic         sw_valid [NSW];
  logic [W-1:0] sw_s     [NSW];
  logic         sw_co    [NSW];
  logic         sw_v     [NSW];

  for (genvar i = 0; i < NSW; i++) begin : g_sweep
    cla_adder_pipe_if #(.WIDTH(W)) sbus ();
    assign sbus.valid_i = sw_valid_in;
    assign sbus.A_i     = sw_a;
    assign sbus.B_i     = sw_b;
    assign sbus.Ci_i    = 1'b0;
    assign sbus.sub_i   = 1'b0;
    assign sbus.ready_i = 1'b1;
    cla_adder_pipe #(.WIDTH(W), .BLOCK(4), .STAGES(SW_STAGES[i])) u_dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (sbus)
    );
    assign sw_valid[i] = sbus.valid_o;
    assign sw_s[i]     = sbus.S_o;
    assign sw_co[i]    = sbus.Co_o;
    assign sw_v[i]     = sbus.V_o;
  end

  // Reference: exact integer arithmetic on 64-bit values.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic ci, input logic sub);
    longint ua, ub, sa, sb, u, r;
    exp_t   e;
    ua = longint'(a);
    ub = longint'(b);
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (!sub) begin
      u    = ua + ub + longint'(ci);
      r    = sa + sb + longint'(ci);
      e.co = (u >= 64'h1_0000_0000);
    end else begin
      u    = ua - ub - longint'(ci);
      r    = sa - sb - longint'(ci);
      e.co = (ua < ub + longint'(ci));
    end
    e.s = u[W-1:0];
    e.v = (r > 64'sd2147483647) || (r < -64'sd2147483648);
    return e;
  endfunction

  function automatic logic [W-1:0] rnd_word();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return '1;
      2:       return 32'h7FFF_FFFF;
      3:       return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  task automatic idle_inputs();
    bus.valid_i = 1'b0;
    bus.A_i     = '0;
    bus.B_i     = '0;
    bus.Ci_i    = 1'b0;
    bus.sub_i   = 1'b0;
    bus.ready_i = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    total++; if (bus.valid_o !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", bus.valid_o); end
    total++; if (bus.S_o !== '0) begin bad++; $display("FAIL reset_sum got=%h want=0", bus.S_o); end
    total++; if ({bus.Co_o, bus.V_o} !== 2'b00) begin bad++; $display("FAIL reset_flags got=%b want=00", {bus.Co_o, bus.V_o}); end
    total++; if (bus.ready_o !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", bus.ready_o); end
    bus.ready_i = 1'b0;
    #1;
    total++; if (bus.ready_o !== 1'b1) begin bad++; $display("FAIL empty_ready_no_sink got=%b want=1", bus.ready_o); end
    bus.ready_i = 1'b1;
  endtask

  task automatic test_directed();
    logic [W-1:0] ta [5] = '{32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000, 32'd5, 32'd10};
    logic [W-1:0] tb [5] = '{32'h0000_0001, 32'h0000_0001, 32'h8000_0000, 32'd7, 32'd3};
    logic         tc [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic         tm [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    exp_t         te [5] = '{'{32'h0, 1'b1, 1'b0}, '{32'h8000_0000, 1'b0, 1'b1},
                            '{32'h0, 1'b1, 1'b1}, '{32'hFFFF_FFFE, 1'b1, 1'b0},
                            '{32'h6, 1'b0, 1'b0}};
    for (int t = 0; t < 5; t++) begin
      int lat;
      @(posedge clk); #1;
      bus.ready_i = 1'b1;
      bus.valid_i = 1'b1;
      bus.A_i     = ta[t];
      bus.B_i     = tb[t];
      bus.Ci_i    = tc[t];
      bus.sub_i   = tm[t];
      lat = 0;
      while (lat < 20) begin
        @(posedge clk); #1;
        lat++;
        bus.valid_i = 1'b0;
        if (bus.valid_o === 1'b1) break;
      end
      total++; if (lat !== 2) begin bad++; $display("FAIL directed%0d_latency got=%0d want=2", t, lat); end
      total++;
      if ({bus.S_o, bus.Co_o, bus.V_o} !== te[t]) begin
        bad++;
        $display("FAIL directed%0d_result got S=%h Co=%b V=%b want S=%h Co=%b V=%b",
                 t, bus.S_o, bus.Co_o, bus.V_o, te[t].s, te[t].co, te[t].v);
      end
    end
  endtask

  // Streams n_ops operations; fixed mode stalls the sink on cycles 4..6,
  // random mode randomises both source gaps and sink readiness.
  task automatic run_stream(input int n_ops, input bit random_mode, input string tag);
    exp_t         q[$];
    exp_t         e;
    exp_t         held_val;
    bit           held = 0;
    bit           presenting = 0;
    int           sent = 0;
    int           recv = 0;
    logic [W-1:0] oa, ob;
    logic         oc, om;
    for (int cyc = 0; cyc < 600 && recv < n_ops; cyc++) begin
      @(posedge clk); #1;
      if (random_mode) bus.ready_i = ($urandom_range(0, 3) != 0);
      else             bus.ready_i = !(cyc >= 4 && cyc <= 6);
      #1;
      if (held) begin
        total++;
        if ({bus.valid_o, bus.S_o, bus.Co_o, bus.V_o} !== {1'b1, held_val}) begin
          bad++;
          $display("FAIL %s_hold cyc=%0d got v=%b S=%h Co=%b V=%b want S=%h Co=%b V=%b", tag, cyc,
                   bus.valid_o, bus.S_o, bus.Co_o, bus.V_o, held_val.s, held_val.co, held_val.v);
        end
      end
      if (!random_mode && cyc >= 4 && cyc <= 6) begin
        total++; if (bus.ready_o !== 1'b0) begin bad++; $display("FAIL %s_stall_ready cyc=%0d got=%b want=0", tag, cyc, bus.ready_o); end
      end
      held = 0;
      if (bus.valid_o === 1'b1) begin
        if (q.size() == 0) begin
          total++; bad++;
          $display("FAIL %s_unexpected cyc=%0d got S=%h want no output", tag, cyc, bus.S_o);
        end else if (bus.ready_i) begin
          e = q.pop_front();
          recv++;
          total++;
          if ({bus.S_o, bus.Co_o, bus.V_o} !== e) begin
            bad++;
            $display("FAIL %s_result#%0d got S=%h Co=%b V=%b want S=%h Co=%b V=%b", tag, recv,
                     bus.S_o, bus.Co_o, bus.V_o, e.s, e.co, e.v);
          end
        end else begin
          held     = 1;
          held_val = q[0];
        end
      end
      if (!presenting && sent < n_ops && (!random_mode || $urandom_range(0, 4) != 0)) begin
        oa = rnd_word();
        ob = rnd_word();
        oc = 1'($urandom_range(0, 1));
        om = 1'($urandom_range(0, 1));
        presenting = 1;
      end
      bus.valid_i = presenting;
      bus.A_i     = oa;
      bus.B_i     = ob;
      bus.Ci_i    = oc;
      bus.sub_i   = om;
      if (presenting && bus.ready_o === 1'b1) begin
        q.push_back(model(oa, ob, oc, om));
        sent++;
        presenting = 0;
      end
    end
    bus.valid_i = 1'b0;
    bus.ready_i = 1'b1;
    total++;
    if (recv != n_ops || sent != n_ops || q.size() != 0) begin
      bad++;
      $display("FAIL %s_count got recv=%0d sent=%0d left=%0d want %0d/%0d/0", tag, recv, sent, q.size(), n_ops, n_ops);
    end
    repeat (3) @(posedge clk);
    #1;
    total++; if (bus.valid_o !== 1'b0) begin bad++; $display("FAIL %s_drained got valid=%b want=0", tag, bus.valid_o); end
  endtask

  task automatic test_back_to_back();
    run_stream(8, 1'b0, "b2b");
  endtask

  task automatic test_random_backpressure();
    run_stream(60, 1'b1, "rnd");
  endtask

  task automatic test_flush();
    bit leaked = 0;
    @(posedge clk); #1;
    bus.ready_i = 1'b1;
    bus.valid_i = 1'b1;
    bus.A_i = 32'h1234_5678; bus.B_i = 32'h1111_1111; bus.Ci_i = 1'b0; bus.sub_i = 1'b0;
    @(posedge clk); #1;
    bus.A_i = 32'hDEAD_BEEF; bus.B_i = 32'h0000_1000; bus.sub_i = 1'b1;
    @(posedge clk); #1;
    total++; if (bus.valid_o !== 1'b1) begin bad++; $display("FAIL flush_inflight got valid=%b want=1", bus.valid_o); end
    bus.valid_i = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    total++; if (bus.valid_o !== 1'b0) begin bad++; $display("FAIL flush_valid got=%b want=0", bus.valid_o); end
    total++; if (bus.S_o !== '0) begin bad++; $display("FAIL flush_sum got=%h want=0", bus.S_o); end
    total++; if (bus.ready_o !== 1'b1) begin bad++; $display("FAIL flush_ready got=%b want=1", bus.ready_o); end
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (bus.valid_o !== 1'b0) leaked = 1;
    end
    total++; if (leaked) begin bad++; $display("FAIL flush_leak got a flushed result want none"); end
  endtask

  task automatic test_sweep();
    int   lat_seen [NSW];
    exp_t got      [NSW];
    for (int i = 0; i < NSW; i++) begin lat_seen[i] = -1; got[i] = '0; end
    @(posedge clk); #1;
    sw_a = 32'h0000_FFFF;
    sw_b = 32'hFFFF_0001;
    sw_valid_in = 1'b1;
    for (int lat = 1; lat <= 20; lat++) begin
      @(posedge clk); #1;
      sw_valid_in = 1'b0;
      for (int i = 0; i < NSW; i++) begin
        if (lat_seen[i] < 0 && sw_valid[i] === 1'b1) begin
          lat_seen[i] = lat;
          got[i]      = '{sw_s[i], sw_co[i], sw_v[i]};
        end
      end
    end
    for (int i = 0; i < NSW; i++) begin
      total++;
      if (lat_seen[i] != SW_STAGES[i]) begin
        bad++; $display("FAIL sweep_latency stages=%0d got=%0d want=%0d", SW_STAGES[i], lat_seen[i], SW_STAGES[i]);
      end
      total++;
      if (got[i] !== exp_t'({32'h0, 1'b1, 1'b0})) begin
        bad++; $display("FAIL sweep_result stages=%0d got S=%h Co=%b V=%b want S=00000000 Co=1 V=0",
                        SW_STAGES[i], got[i].s, got[i].co, got[i].v);
      end
    end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_directed();
    test_back_to_back();
    test_random_backpressure();
    test_flush();
    test_sweep();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/cla_adder_pipe.md
Name: cla_adder_pipe

Overview:
Parametrised, pipelined carry-lookahead adder/subtractor. It is the wide successor to the 16-bit flat CLA and feeds the square-root datapath and later arithmetic units. The operand width is split into BLOCK-bit lookahead groups, and the groups are spread across STAGES register stages. Each stage ripples a group carry, so there is no flat 16-term carry equation. Adds a subtract/borrow mode, signed overflow, and a valid/ready stream handshake with backpressure.

Parameters:
WIDTH, 32, operand and sum width in bits; must be a multiple of BLOCK.
BLOCK, 4, bits per lookahead group.
STAGES, 2, number of register stages (= latency); 1 <= STAGES <= WIDTH/BLOCK, and (WIDTH/BLOCK) % STAGES == 0.

Ports:
clk_i  in  1  clock, all state updates on rising edge
rst_i  in  1  synchronous reset, active-high
valid_i  in  1  input operands valid
ready_o  out  1  block can accept input this cycle
A_i  in  WIDTH  operand A
B_i  in  WIDTH  operand B
Ci_i  in  1  carry-in (add) / borrow-in (sub)
sub_i  in  1  0 = A+B+Ci, 1 = A-B-Ci
valid_o  out  1  result valid
ready_i  in  1  downstream accepts result
S_o  out  WIDTH  sum/difference
Co_o  out  1  carry-out (add) / borrow-out (sub)
V_o  out  1  two's-complement overflow

Behaviour:
- Interface: one clock clk_i; rst_i is synchronous, active-high.
- Reset: all stage valid bits are 0, all data registers are 0. valid_o=0, S_o=0, Co_o=0, V_o=0, and ready_o=1 in the first cycle after reset.
- Reset mid-operation flushes every in-flight operation. Nothing accepted before reset ever appears at the output.
- Operand conditioning at input:
  - B_eff = sub_i ? ~B_i : B_i
  - cin = sub_i ? ~Ci_i : Ci_i
- Group g (0..WIDTH/BLOCK-1):
  - Bit p = A^B_eff and g = A&B_eff, lookahead inside the group.
  - Group GG/PG and group carry-out = GG | (PG & group carry-in).
  - Sum bit = p ^ internal carry.
- Stage k computes groups k*N .. k*N+N-1 with N = WIDTH/(BLOCK*STAGES).
  - Within a stage, group carries chain combinationally.
  - Between stages, the following are registered: the carry, the already-computed sum bits, the not-yet-consumed operand bits, and sub_i.
- Final stage outputs:
  - Co_o = sub ? ~cout : cout
  - V_o = carry into MSB ^ carry out of MSB (mode-independent)
- Latency: an operand accepted on cycle t appears with valid_o=1 on cycle t+STAGES when there are no stalls.
- Handshake:
  - Transfer in when valid_i & ready_o; transfer out when valid_o & ready_i.
  - Global advance en = ~valid_o | ready_i, and ready_o = en.
  - When en=0, every stage register holds; S_o/Co_o/V_o/valid_o stay stable until accepted.
  - Bubbles are not compressed.
- Throughput: one operation per cycle with ready_i held 1.
- valid_i when ready_o=0: input is ignored; the upstream must hold it.
- Wrap-around: S_o is the modulo-2^WIDTH result; the carry/borrow appears only on Co_o.
- Illegal parameter combinations cause an elaboration-time error; there is no silent truncation.

Decomposition:
- Package cla_pkg holds:
  - the function/constant for the group count (WIDTH/BLOCK) and groups per stage;
  - a parameter-check macro;
  - the typedef for the stage pipeline record: valid, sub, carry, partial sum, remaining A/B.
- One natural sub-module: cla_group. It is a BLOCK-bit combinational lookahead group with ports a, b, cin -> s, cout, gg, pg, and it is instantiated WIDTH/BLOCK times via generate.

Test Plan:
1. WIDTH=32/BLOCK=4/STAGES=2, add 0xFFFFFFFF+0x00000001, Ci=0 -> 2 cycles later S_o=0x00000000, Co_o=1, V_o=0, valid_o=1.
2. Add 0x7FFFFFFF+0x00000001, Ci=0 -> S_o=0x80000000, Co_o=0, V_o=1. Then 0x80000000+0x80000000 -> S_o=0, Co_o=1, V_o=1.
3. sub_i=1: 5-7, Ci=0 -> S_o=0xFFFFFFFE, Co_o=1 (borrow), V_o=0. Then 10-3 with Ci=1 -> S_o=6, Co_o=0.
4. Stream 8 back-to-back random ops with ready_i=0 for cycles 4-6 -> ready_o=0 during the stall, outputs held stable, all 8 results match the model in order, no loss or duplication.
5. Two ops in flight, then rst_i=1 for one cycle -> next cycle valid_o=0, S_o=0, ready_o=1; the flushed ops never appear.
6. Sweep STAGES in {1,2,4,8} with 0x0000FFFF+0xFFFF0001 -> S_o=0x00000000, Co_o=1, with latency equal to STAGES. Then STAGES=3 -> elaboration error.
